ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the same open-drain `ps2_clk`/`ps2_data` pair used by the keyboard receiver. It sits beside `kb_interface` in the `clk65MHz` domain. It performs the inhibit/request-to-send sequence, shifts the frame out on device-generated clock edges, and checks the device ACK. While it owns the bus it asserts `busy`, which the receiver must use to ignore traffic.

## Interface
Parameters:
- `INHIBIT_CYCLES`, 6500 — clock-low inhibit time before request (100 µs @ 65 MHz).
- `START_HOLD_CYCLES`, 65 — clock and data both held low before releasing clock (1 µs).
- `TIMEOUT_CYCLES`, 975000 — watchdog limit per transfer (15 ms); used only with `PS2_TX_TIMEOUT_EN`.

Ports:
- `clk` in 1 — system clock (`clk65MHz`).
- `rst` in 1 — reset: synchronous, active-low.
- `tx_start` in 1 — one-cycle request; accepted only when `tx_ready`=1.
- `tx_data` in 8 — byte to send; captured on the accepting cycle.
- `ps2_clk_in` in 1 — PS/2 clock pin, asynchronous.
- `ps2_data_in` in 1 — PS/2 data pin, asynchronous.
- `ps2_clk_oe` out 1 — 1 = pull clock line low, 0 = release (high-Z).
- `ps2_data_oe` out 1 — 1 = pull data line low, 0 = release.
- `tx_ready` out 1 — idle, ready to accept.
- `busy` out 1 — transfer in progress; equal to `~tx_ready`.
- `tx_done` out 1 — one-cycle pulse: frame sent and ACK received.
- `tx_error` out 1 — one-cycle pulse: NACK, or watchdog timeout.

## Operation
- Inputs pass through a 2-FF synchronizer. A falling edge `fe` is detected on the synchronized clock (registered compare), adding 1 cycle.
- Frame register `frame[10:0]` = {stop=1, parity, tx_data[7:0], start=0}. Parity is odd: `~^tx_data`. `ps2_data_oe = ~frame[idx]` while in SHIFT.
- FSM:
  - IDLE: both oe=0, `tx_ready`=1. On `tx_start` → INHIBIT, latch data, clear counters.
  - INHIBIT: `ps2_clk_oe`=1 for `INHIBIT_CYCLES` cycles → START.
  - START: `ps2_clk_oe`=1, `ps2_data_oe`=1 for `START_HOLD_CYCLES` → SHIFT with idx=0 and `ps2_clk_oe`=0. Data stays low because the start bit is 0.
  - SHIFT: each `fe` increments idx. idx 1..8 drive data bits LSB first, idx 9 drives parity, idx 10 drives stop (data released). `fe` at idx=10 → ACK.
  - ACK: on the next `fe` (11th), sample synced data. 0 → WAIT_IDLE. 1 → pulse `tx_error`, go to IDLE.
  - WAIT_IDLE: wait until synced clk=1 and data=1 → pulse `tx_done`, go to IDLE.
- `tx_start` while busy is ignored; no queueing.
- `tx_done` and `tx_error` never assert in the same cycle.
- Reset (any state, mid-frame included): state IDLE, both oe=0, `tx_ready`=1, `busy`=0, `tx_done`=0, `tx_error`=0, idx=0, counters 0.

## Timing
- `tx_start` at cycle N → `ps2_clk_oe`=1 at N+1 (registered outputs).
- `ps2_clk_oe` is high for exactly `INHIBIT_CYCLES + START_HOLD_CYCLES` cycles.
- `ps2_data_oe` rises at INHIBIT→START and stays high through idx=0.
- Pin falling edge at cycle P → `ps2_data_oe` updates at P+4: 2 sync stages, 1 edge register, 1 output register. This is well inside the device's ≥5 µs low half-period.
- ACK sample uses the same `fe` alignment as bit shifts.
- `tx_done` asserts 1 cycle after both synced lines read high. `tx_ready` returns 1 in the same cycle.
- Counters are wide enough for their parameters: 13 bits inhibit, 7 bits hold, 20 bits timeout. No wrap in normal use.

## Configuration
- `PS2_TX_TIMEOUT_EN` defined: a watchdog counts cycles from leaving IDLE and resets on entry to IDLE. Reaching `TIMEOUT_CYCLES` in any non-IDLE state pulses `tx_error`, forces both oe=0, and returns to IDLE. This covers an absent keyboard or a stuck clock.
- Undefined: no watchdog logic. Without device clocks the FSM waits in SHIFT/ACK/WAIT_IDLE until reset.

## Test plan
- Send 0xED with a device model clocking at 12.5 kHz and ACKing → data line bits after start read 1,0,1,1,0,1,1,1, parity=1, stop=1; one `tx_done` pulse; no `tx_error`.
- Send 0x01 → parity bit 0; send 0x00 → parity bit 1; send 0xFF → parity bit 1; each completes with `tx_done`.
- Device holds data high on the 11th clock (NACK) → `tx_error` pulse, return to IDLE, `tx_ready`=1 one cycle later.
- Check inhibit timing → `ps2_clk_oe` high for exactly 6565 cycles; `ps2_data_oe` rises at cycle 6501 after the accept cycle. Second `tx_start` mid-frame → ignored, frame unchanged.
- `rst`=0 asserted at idx=5 → next cycle both oe=0, `busy`=0. A new 0xFF transfer afterwards completes normally.
- With `PS2_TX_TIMEOUT_EN`, no device clocks → `tx_error` exactly `TIMEOUT_CYCLES` after leaving IDLE, both oe=0. Without the macro → `busy` stays 1.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift on device clock, ACK check.
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES    = 6500,
    parameter int START_HOLD_CYCLES = 65,
    parameter int TIMEOUT_CYCLES    = 975000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_START     = 3'd2,
        S_SHIFT     = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    localparam logic [12:0] INH_LAST  = 13'(INHIBIT_CYCLES - 1);
    localparam logic [6:0]  HOLD_LAST = 7'(START_HOLD_CYCLES - 1);

    state_t      r_state;
    logic [10:0] r_frame;
    logic [3:0]  r_idx;
    logic [12:0] r_inh_cnt;
    logic [6:0]  r_hold_cnt;
    logic        r_clk_oe;
    logic        r_data_oe;
    logic        r_tx_ready;
    logic        r_tx_done;
    logic        r_tx_error;

    logic r_clk_s1, r_clk_s2, r_clk_prev;
    logic r_data_s1, r_data_s2;
    logic r_fe;
    logic [3:0] w_idx_next;

    assign w_idx_next = r_idx + 4'd1;

    // Idle bus lines are pulled high, so the synchronizer resets to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_data_s1  <= 1'b1;
            r_data_s2  <= 1'b1;
            r_fe       <= 1'b0;
        end else begin
            r_clk_s1   <= ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_data_s1  <= ps2_data_in;
            r_data_s2  <= r_data_s1;
            r_fe       <= r_clk_prev & ~r_clk_s2;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [19:0] WD_LAST = 20'(TIMEOUT_CYCLES - 1);
    logic [19:0] r_wd_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Handshake: a request is taken on any cycle where tx_start=1 and tx_ready=1;
    // tx_data is captured in that same cycle and tx_start is ignored otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_frame    <= 11'h7FF;
            r_idx      <= 4'd0;
            r_inh_cnt  <= 13'd0;
            r_hold_cnt <= 7'd0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_tx_ready <= 1'b1;
            r_tx_done  <= 1'b0;
            r_tx_error <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            r_wd_cnt   <= 20'd0;
`endif
        end else begin
            r_tx_done  <= 1'b0;
            r_tx_error <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            if (r_state != S_IDLE) begin
                r_wd_cnt <= r_wd_cnt + 20'd1;
            end
`endif
            case (r_state)
                S_IDLE: begin
`ifdef PS2_TX_TIMEOUT_EN
                    r_wd_cnt <= 20'd0;
`endif
                    if (tx_start) begin
                        r_state    <= S_INHIBIT;
                        r_frame    <= {1'b1, ~^tx_data, tx_data, 1'b0};
                        r_idx      <= 4'd0;
                        r_inh_cnt  <= 13'd0;
                        r_hold_cnt <= 7'd0;
                        r_clk_oe   <= 1'b1;
                        r_tx_ready <= 1'b0;
                    end
                end
                S_INHIBIT: begin
                    if (r_inh_cnt == INH_LAST) begin
                        r_state   <= S_START;
                        r_data_oe <= 1'b1;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + 13'd1;
                    end
                end
                S_START: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state   <= S_SHIFT;
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= ~r_frame[0];
                        r_idx     <= 4'd0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 7'd1;
                    end
                end
                S_SHIFT: begin
                    // The tenth falling edge puts the stop bit (line released) on the bus.
                    if (r_fe) begin
                        r_idx     <= w_idx_next;
                        r_data_oe <= ~r_frame[w_idx_next];
                        if (r_idx == 4'd9) begin
                            r_state <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    r_data_oe <= 1'b0;
                    if (r_fe) begin
                        if (!r_data_s2) begin
                            r_state <= S_WAIT_IDLE;
                        end else begin
                            r_state    <= S_IDLE;
                            r_tx_error <= 1'b1;
                            r_tx_ready <= 1'b1;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    r_data_oe <= 1'b0;
                    if (r_clk_s2 && r_data_s2) begin
                        r_state    <= S_IDLE;
                        r_tx_done  <= 1'b1;
                        r_tx_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_clk_oe   <= 1'b0;
                    r_data_oe  <= 1'b0;
                    r_tx_ready <= 1'b1;
                end
            endcase
`ifdef PS2_TX_TIMEOUT_EN
            // Watchdog wins over every state action so done and error stay exclusive.
            if (r_state != S_IDLE && r_wd_cnt == WD_LAST) begin
                r_state    <= S_IDLE;
                r_clk_oe   <= 1'b0;
                r_data_oe  <= 1'b0;
                r_tx_done  <= 1'b0;
                r_tx_error <= 1'b1;
                r_tx_ready <= 1'b1;
            end
`endif
        end
    end

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign tx_ready    = r_tx_ready;
    assign busy        = ~r_tx_ready;
    assign tx_done     = r_tx_done;
    assign tx_error    = r_tx_error;
    assign o_dbg_state = r_state;

endmodule
